// File: rtl/address_generator_pkg.sv
// Shared BIST address definitions: default address width, the address
// type, and the sweep end-point constants used by the address counter.
package address_generator_pkg;

  localparam int unsigned BIST_ADDR_W = 8;

  typedef logic [BIST_ADDR_W-1:0] addr_t;

  localparam addr_t ADDR_MIN = '0;
  localparam addr_t ADDR_MAX = '1;

endpackage : address_generator_pkg

// File: rtl/address_generator.sv
// Synchronous up/down address counter for the BIST engine.
// Sweeps the address space in either direction, can be cleared or preset
// to the top address, and flags the terminal address so the controller can
// advance to the next march element.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset    - synchronous active-high clear (highest priority)
//   preset   - synchronous load of the all-ones address
//   en       - count enable
//   up_down  - count direction, 1 = increment, 0 = decrement
//   address  - current address (registered)
//   carry    - terminal-count flag (combinational): next enabled edge wraps
module address_generator
  import address_generator_pkg::*;
#(
  parameter int unsigned ADDR_W = BIST_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              preset,
  input  logic              en,
  input  logic              up_down,
  output logic [ADDR_W-1:0] address,
  output logic              carry
);

  localparam logic [ADDR_W-1:0] A_MIN = '0;
  localparam logic [ADDR_W-1:0] A_MAX = '1;

  // True when the next step in direction dir leaves the address range.
  function automatic logic at_terminal(input logic [ADDR_W-1:0] a,
                                       input logic              dir);
    return dir ? (a == A_MAX) : (a == A_MIN);
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      address <= A_MIN;
    else if (preset)
      address <= A_MAX;
    else if (en) begin
      if (up_down)
        address <= address + 1'b1;
      else
        address <= address - 1'b1;
    end
  end

  always_comb begin
    carry = 1'b0;
    if (!reset && !preset)
      carry = en & at_terminal(address, up_down);
  end

  // Checks are held off until the first reset, since the address has no
  // defined value before then.
  logic armed;

  always_ff @(posedge clk) begin
    if (reset)
      armed <= 1'b1;
  end

  a_reset_priority: assert property (@(posedge clk)
    reset |=> (address == A_MIN));

  a_preset_load: assert property (@(posedge clk) disable iff (!armed)
    (!reset && preset) |=> (address == A_MAX));

  a_wrap_up: assert property (@(posedge clk) disable iff (!armed)
    (!reset && !preset && en && up_down && address == A_MAX)
      |=> (address == A_MIN));

  a_wrap_down: assert property (@(posedge clk) disable iff (!armed)
    (!reset && !preset && en && !up_down && address == A_MIN)
      |=> (address == A_MAX));

  // In a continuous count in one direction a carry cannot repeat on the
  // following cycle; a direction flip right after a wrap legitimately can.
  a_carry_single: assert property (@(posedge clk) disable iff (!armed)
    carry ##1 (en && !reset && !preset && up_down == $past(up_down))
      |-> !carry);

endmodule : address_generator

// File: tb/tb_address_generator.sv
module tb_address_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       preset;
  logic       en;
  logic       up_down;
  logic [7:0] address;
  logic       carry;

  int unsigned total = 0;
  int unsigned bad   = 0;

  address_generator #(.ADDR_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .preset  (preset),
    .en      (en),
    .up_down (up_down),
    .address (address),
    .carry   (carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned carries;
    reset = 1'b1; preset = 1'b0; en = 1'b1; up_down = 1'b0;

    // Reset: carry would be 1 at 0x00 counting down, but reset forces it low.
    tick();
    check("reset_addr", 32'(address), 32'h00);
    check("reset_carry", 32'(carry), 32'h0);

    // Preset with en/up held: carry forced low while preset asserted.
    reset = 1'b0; preset = 1'b1; en = 1'b1; up_down = 1'b1;
    tick();
    check("preset_addr", 32'(address), 32'hFF);
    check("preset_carry", 32'(carry), 32'h0);

    // Up wrap from 0xFF.
    preset = 1'b0;
    #1;
    check("up_wrap_carry", 32'(carry), 32'h1);
    tick();
    check("up_wrap_addr", 32'(address), 32'h00);
    check("up_wrap_carry_after", 32'(carry), 32'h0);

    for (int i = 1; i <= 12; i++) begin
      tick();
      check("count_up", 32'(address), 32'(i));
    end

    // Direction change at 0x0C, no dead cycle.
    up_down = 1'b0;
    #1;
    check("down_carry_low", 32'(carry), 32'h0);
    for (int i = 11; i >= 0; i--) begin
      tick();
      check("count_down", 32'(address), 32'(i));
    end
    check("down_wrap_carry", 32'(carry), 32'h1);
    tick();
    check("down_wrap_addr", 32'(address), 32'hFF);

    // Full down sweep: 256 enabled edges return to 0xFF, one carry.
    carries = 0;
    for (int i = 0; i < 256; i++) begin
      if (carry) carries++;
      tick();
    end
    check("sweep_addr", 32'(address), 32'hFF);
    check("sweep_carries", carries, 32'd1);

    // Hold with en=0.
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_carry", 32'(carry), 32'h0);
      tick();
      check("hold_addr", 32'(address), 32'hFF);
    end

    // reset + preset + en together: reset wins.
    reset = 1'b1; preset = 1'b1; en = 1'b1; up_down = 1'b1;
    tick();
    check("prio_addr", 32'(address), 32'h00);

    // Mid-count reset at 0x37.
    reset = 1'b0; preset = 1'b0;
    for (int i = 0; i < 8'h37; i++) tick();
    check("mid_reach", 32'(address), 32'h37);
    reset = 1'b1;
    tick();
    check("mid_reset_addr", 32'(address), 32'h00);
    reset = 1'b0;
    tick();
    check("mid_resume_addr", 32'(address), 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_address_generator
